// File: rtl/pipe_pkg.sv
// Shared pipeline types: MEM-stage FSM states and the MEM/WB writeback payload.
// Used by the EX, MEM and WB stages so the payload layout stays in one place.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] reg_dest;
    logic [XLEN-1:0]       data;
  } wb_payload_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Ack watchdog for the MEM stage (present only with MEM_TIMEOUT_EN); expired is combinational
// and rises in the LIMIT-th consecutive run cycle; no backpressure, it only observes the FSM.
module mem_timeout_ctr #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LIMIT-1 so a held-off abort cannot wrap and re-arm.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = '0;
    end else if (run && (cnt_q != CW'(LIMIT - 1))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = run && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: ALU ops retire in 1 cycle, loads/stores wait on dmem ack (MEM_TIMEOUT_EN adds a watchdog).
// in_ready is low for the whole ACCESS state, stalling EX and everything upstream.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [REG_ADDR_W-1:0] reg_dest,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_reg_dest,
  output logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     fwd_mem_data,
  output logic                  misalign_err,
  output logic                  timeout_err
);

  mem_state_t            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [REG_ADDR_W-1:0] dest_q, dest_d;
  logic                  rw_q, rw_d;
  logic                  we_q, we_d;
  logic                  wb_vld_q, wb_vld_d;
  wb_payload_t           wb_q, wb_d;
  logic                  misalign_q, misalign_d;
  logic                  timeout_q, timeout_d;

  logic accept;
  logic mem_op;
  logic is_store;
  logic enter_access;
  logic tmo_expired;

  assign accept   = in_valid && in_ready;
  assign mem_op   = mem_read || mem_write;
  assign is_store = mem_write && !mem_read;

`ifdef MEM_TIMEOUT_EN
  mem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (enter_access),
    .run     (state_q == ACCESS),
    .expired (tmo_expired)
  );
`else
  logic unused_timeout_cfg;
  assign tmo_expired        = 1'b0;
  assign unused_timeout_cfg = enter_access & (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    dest_d       = dest_q;
    rw_d         = rw_q;
    we_d         = we_q;
    wb_vld_d     = 1'b0;
    wb_d         = wb_q;
    misalign_d   = misalign_q;
    timeout_d    = timeout_q;
    enter_access = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!mem_op) begin
            wb_vld_d     = 1'b1;
            wb_d.reg_write = reg_write;
            wb_d.reg_dest  = reg_dest;
            wb_d.data      = XLEN'(alu_result);
          end else if (is_misaligned(alu_result[1:0])) begin
            // Faulting access retires as a bubble so WB keeps its slot count.
            misalign_d     = 1'b1;
            wb_vld_d       = 1'b1;
            wb_d.reg_write = 1'b0;
            wb_d.reg_dest  = reg_dest;
            wb_d.data      = XLEN'(alu_result);
          end else begin
            state_d      = ACCESS;
            enter_access = 1'b1;
            addr_d       = alu_result[ADDR_W-1:0];
            wdata_d      = store_data;
            dest_d       = reg_dest;
            rw_d         = reg_write;
            we_d         = is_store;
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d        = IDLE;
          wb_vld_d       = 1'b1;
          wb_d.reg_write = rw_q && !we_q;
          wb_d.reg_dest  = dest_q;
          wb_d.data      = we_q ? XLEN'(addr_q) : XLEN'(dmem_rdata);
        end else if (tmo_expired) begin
          state_d        = IDLE;
          timeout_d      = 1'b1;
          wb_vld_d       = 1'b1;
          wb_d.reg_write = 1'b0;
          wb_d.reg_dest  = dest_q;
          wb_d.data      = XLEN'(addr_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      dest_q     <= '0;
      rw_q       <= 1'b0;
      we_q       <= 1'b0;
      wb_vld_q   <= 1'b0;
      wb_q       <= '0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dest_q     <= dest_d;
      rw_q       <= rw_d;
      we_q       <= we_d;
      wb_vld_q   <= wb_vld_d;
      wb_q       <= wb_d;
      misalign_q <= misalign_d;
      timeout_q  <= timeout_d;
    end
  end

  // Request derives from state alone so an async reset drops it without a clock.
  assign in_ready     = (state_q == IDLE);
  assign dmem_req     = (state_q == ACCESS);
  assign dmem_we      = (state_q == ACCESS) && we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_vld_q;
  assign wb_reg_write = wb_q.reg_write;
  assign wb_reg_dest  = wb_q.reg_dest;
  assign wb_data      = DATA_W'(wb_q.data);
  assign fwd_mem_data = DATA_W'(wb_q.data);
  assign misalign_err = misalign_q;
  assign timeout_err  = timeout_q;

endmodule
